// File: rtl/diaosi_types_pkg.sv
// -----------------------------------------------------------------------------
// diaosi_types_pkg
//   Shared types and constants for the memory-side arbitration logic.
//   - arb_state_t : bus arbiter FSM state encoding
//   - ARB_NREQ    : number of RAM requesters (icache/dcache of both cores)
//   - ARB_BEATS   : words per block transfer (dcache fill / writeback)
//   - C0I..C1D    : requester index map used by gnt/gnt_id
// -----------------------------------------------------------------------------
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1
  } arb_state_t;

  localparam int ARB_NREQ  = 4;
  localparam int ARB_BEATS = 2;

  // Requester index order on req/gnt vectors.
  localparam int C0I = 0;  // core 0 icache
  localparam int C0D = 1;  // core 0 dcache
  localparam int C1I = 2;  // core 1 icache
  localparam int C1D = 3;  // core 1 dcache

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority encoder. Returns the first set bit of vec
//   in the search order ptr, ptr+1, ... wrapping modulo NREQ.
// Ports
//   vec     in   NREQ  candidate request vector
//   ptr     in   IDW   index searched first
//   onehot  out  NREQ  one-hot winner (zero when vec is zero)
//   id      out  IDW   binary index of the winner (zero when vec is zero)
//   any     out  1     vec has at least one bit set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] vec,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] src;

  // mask keeps the indices at or above ptr. The lowest set bit of the masked
  // vector is the next candidate in rotation order; if nothing is set there,
  // the search has wrapped and the lowest set bit of the full vector wins.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign masked = vec & mask;
  assign src    = (|masked) ? masked : vec;
  assign any    = |vec;

  always_comb begin
    id = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (src[k]) begin
        id = IDW'(k);
      end
    end
  end

  always_comb begin
    onehot = '0;
    if (any) begin
      onehot[id] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//   Grants the shared RAM port to one of NREQ requesters. Writeback requests
//   (req_hi) beat reads/fills; each class rotates round-robin on its own
//   pointer. A grant is held for a whole transaction (1 or BEATS words), then
//   released for at least one cycle before the next grant.
// Ports
//   CLK      in   1     system clock, rising edge
//   RST      in   1     asynchronous active-high reset
//   req      in   NREQ  per-requester request level, held until done
//   req_hi   in   NREQ  hi-priority class (writeback), qualified by req
//   req_blk  in   NREQ  1 = BEATS-word transfer, 0 = single word
//   ram_ack  in   1     RAM accepted one word this cycle
//   gnt      out  NREQ  registered one-hot grant
//   gnt_id   out  IDW   binary index of granted requester, valid when busy
//   busy     out  1     a grant is active
//   beat     out  IDW   word index within current transaction
//   done     out  1     pulse the cycle after the final ram_ack
//   abort    out  1     pulse when the granted requester dropped req early
// -----------------------------------------------------------------------------
module bus_rr_arbiter
  import diaosi_types_pkg::*;
#(
  parameter int NREQ  = ARB_NREQ,
  parameter int BEATS = ARB_BEATS,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_hi,
  input  logic [NREQ-1:0] req_blk,
  input  logic            ram_ack,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic [IDW-1:0]  beat,
  output logic            done,
  output logic            abort
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_t      state_reg,  state_next;
  logic [IDW-1:0]  ptr_hi_reg, ptr_hi_next;
  logic [IDW-1:0]  ptr_lo_reg, ptr_lo_next;
  logic [NREQ-1:0] gnt_reg,    gnt_next;
  logic [IDW-1:0]  gnt_id_reg, gnt_id_next;
  logic [IDW-1:0]  beat_reg,   beat_next;
  logic            done_reg,   done_next;
  logic            abort_reg,  abort_next;
  // Transaction attributes captured at grant time; later changes on the
  // requester's inputs must not alter an in-flight transaction.
  logic            blk_reg,    blk_next;
  logic            cls_hi_reg, cls_hi_next;

  // ---------------------------------------------------------------------------
  // Per-class pickers and class mux
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] hi_vec;
  logic [NREQ-1:0] hi_onehot, lo_onehot;
  logic [IDW-1:0]  hi_id,     lo_id;
  logic            hi_any,    lo_any;
  logic [NREQ-1:0] pick_onehot;
  logic [IDW-1:0]  pick_id;

  // req_hi only counts for requesters that are actually requesting.
  assign hi_vec = req & req_hi;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick_hi (
    .vec    (hi_vec),
    .ptr    (ptr_hi_reg),
    .onehot (hi_onehot),
    .id     (hi_id),
    .any    (hi_any)
  );

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick_lo (
    .vec    (req),
    .ptr    (ptr_lo_reg),
    .onehot (lo_onehot),
    .id     (lo_id),
    .any    (lo_any)
  );

  assign pick_onehot = hi_any ? hi_onehot : lo_onehot;
  assign pick_id     = hi_any ? hi_id     : lo_id;

  // ---------------------------------------------------------------------------
  // Transaction bookkeeping helpers
  // ---------------------------------------------------------------------------
  logic           last_word;
  logic           req_granted;
  logic [IDW-1:0] ptr_after;

  assign last_word   = blk_reg ? (beat_reg == IDW'(BEATS - 1)) : (beat_reg == '0);
  assign req_granted = req[gnt_id_reg];
  // Rotate past the requester just served so it goes to the back of its class.
  assign ptr_after   = (int'(gnt_id_reg) == NREQ - 1) ? '0 : gnt_id_reg + IDW'(1);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    ptr_hi_next = ptr_hi_reg;
    ptr_lo_next = ptr_lo_reg;
    gnt_next    = gnt_reg;
    gnt_id_next = gnt_id_reg;
    beat_next   = beat_reg;
    blk_next    = blk_reg;
    cls_hi_next = cls_hi_reg;
    done_next   = 1'b0;
    abort_next  = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        // Entering IDLE always clears gnt, so any grant issued here is at
        // least one cycle after the previous one was released.
        if (lo_any) begin
          state_next  = ARB_GRANT;
          gnt_next    = pick_onehot;
          gnt_id_next = pick_id;
          blk_next    = req_blk[pick_id];
          cls_hi_next = hi_any;
          beat_next   = '0;
        end
      end

      ARB_GRANT: begin
        // An ack in the same cycle as a req drop still completes the word,
        // so the ack branch is checked first.
        if (ram_ack) begin
          if (last_word) begin
            done_next = 1'b1;
          end else begin
            beat_next = beat_reg + IDW'(1);
          end
        end else if (!req_granted) begin
          abort_next = 1'b1;
        end

        if ((ram_ack && last_word) || (!ram_ack && !req_granted)) begin
          state_next = ARB_IDLE;
          gnt_next   = '0;
          beat_next  = '0;
          if (cls_hi_reg) begin
            ptr_hi_next = ptr_after;
          end else begin
            ptr_lo_next = ptr_after;
          end
        end
      end

      default: begin
        state_next = ARB_IDLE;
        gnt_next   = '0;
        beat_next  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= ARB_IDLE;
      ptr_hi_reg <= '0;
      ptr_lo_reg <= '0;
      gnt_reg    <= '0;
      gnt_id_reg <= '0;
      beat_reg   <= '0;
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
      blk_reg    <= 1'b0;
      cls_hi_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_hi_reg <= ptr_hi_next;
      ptr_lo_reg <= ptr_lo_next;
      gnt_reg    <= gnt_next;
      gnt_id_reg <= gnt_id_next;
      beat_reg   <= beat_next;
      done_reg   <= done_next;
      abort_reg  <= abort_next;
      blk_reg    <= blk_next;
      cls_hi_reg <= cls_hi_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign busy   = (state_reg == ARB_GRANT);
  assign beat   = beat_reg;
  assign done   = done_reg;
  assign abort  = abort_reg;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//   Directed bench for bus_rr_arbiter. Expected grants are queued when the
//   request pattern is driven and popped when the arbiter issues a grant.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] req;
  logic [3:0] req_hi;
  logic [3:0] req_blk;
  logic       ram_ack;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [1:0] beat;
  logic       done;
  logic       abort;

  int n_checks = 0;
  int n_fails  = 0;
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  bus_rr_arbiter #(
    .NREQ  (4),
    .BEATS (2),
    .IDW   (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .req_hi  (req_hi),
    .req_blk (req_blk),
    .ram_ack (ram_ack),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .beat    (beat),
    .done    (done),
    .abort   (abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One clock edge, then the arbiter must present the next queued grant.
  task automatic expect_grant(input string tag);
    logic [3:0] e;
    int id;
    step();
    if (exp_q.size() == 0) begin
      n_fails++;
      $error("FAIL %s: scoreboard empty, observed gnt %b", tag, gnt);
    end else begin
      e  = exp_q.pop_front();
      id = 0;
      for (int k = 0; k < 4; k++) if (e[k]) id = k;
      chk({tag, "_gnt"},    32'(gnt),    32'(e));
      chk({tag, "_gnt_id"}, 32'(gnt_id), 32'(id));
      chk({tag, "_busy"},   32'(busy),   32'd1);
      chk({tag, "_beat0"},  32'(beat),   32'd0);
      $display("txn %s: grant gnt=%b gnt_id=%0d", tag, gnt, gnt_id);
    end
  endtask

  // Final ack of a transaction: done next cycle with grant released.
  task automatic finish_txn(input string tag);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    chk({tag, "_done"},  32'(done),  32'd1);
    chk({tag, "_abort"}, 32'(abort), 32'd0);
    chk({tag, "_gnt0"},  32'(gnt),   32'd0);
    chk({tag, "_busy0"}, 32'(busy),  32'd0);
    chk({tag, "_beatr"}, 32'(beat),  32'd0);
    $display("txn %s: done", tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] hi_during [4];
    logic [3:0] pri_exp   [4];

    RST = 1'b1; req = '0; req_hi = '0; req_blk = '0; ram_ack = 1'b0;
    repeat (3) step();
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_beat",   32'(beat),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_abort",  32'(abort),  32'd0);
    RST = 1'b0;
    step();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Single-word request from index 0; ack two cycles after the grant.
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    expect_grant("single");
    step();
    chk("single_hold", 32'(gnt),  32'h1);
    chk("single_nodn", 32'(done), 32'd0);
    finish_txn("single");
    req = 4'b0000;
    step();
    chk("single_pulse", 32'(done), 32'd0);

    // Contention 0 vs 2; ptr_lo is 1 after the single transfer.
    req = 4'b0101;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    for (int i = 0; i < 3; i++) begin
      expect_grant("contend");
      finish_txn("contend");
    end
    req = 4'b0000;
    step();
    chk("contend_idle", 32'(busy), 32'd0);

    // Priority: hi beats lo, no preemption, each class keeps its own pointer.
    hi_during = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
    pri_exp   = '{4'b0100, 4'b1000, 4'b0010, 4'b0001};
    req    = 4'b1111;
    req_hi = 4'b0100;
    for (int i = 0; i < 4; i++) exp_q.push_back(pri_exp[i]);
    for (int i = 0; i < 4; i++) begin
      expect_grant("prio");
      req_hi = hi_during[i];
      step();
      chk("prio_nopreempt", 32'(gnt), 32'(pri_exp[i]));
      finish_txn("prio");
    end
    req = 4'b0000; req_hi = 4'b0000;
    step();

    // ram_ack with no grant has no effect.
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    chk("idleack_busy", 32'(busy), 32'd0);
    chk("idleack_done", 32'(done), 32'd0);

    // Block transfer from index 1; req_blk change after grant is ignored.
    req = 4'b0010; req_blk = 4'b0010;
    exp_q.push_back(4'b0010);
    expect_grant("block");
    req_blk = 4'b0000;
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    chk("block_beat1", 32'(beat), 32'd1);
    chk("block_nodn",  32'(done), 32'd0);
    chk("block_hold",  32'(gnt),  32'h2);
    step();
    chk("block_beat1b", 32'(beat), 32'd1);
    chk("block_busy",   32'(busy), 32'd1);
    finish_txn("block");
    req = 4'b0000;
    step();

    // Abort: index 2 drops req before any ack; index 0 is served next.
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    expect_grant("abort");
    req = 4'b0001;
    step();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_nodn",  32'(done),  32'd0);
    chk("abort_gnt0",  32'(gnt),   32'd0);
    chk("abort_busy0", 32'(busy),  32'd0);
    $display("txn abort: aborted");
    exp_q.push_back(4'b0001);
    expect_grant("after_abort");
    chk("abort_clear", 32'(abort), 32'd0);
    // Ack and req drop in the same cycle: the ack completes the transfer.
    req = 4'b0000;
    finish_txn("ack_wins");

    // Asynchronous reset in the middle of a block transfer.
    req = 4'b1000; req_blk = 4'b1000;
    exp_q.push_back(4'b1000);
    expect_grant("rstblk");
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    chk("rstblk_beat1", 32'(beat), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("rstblk_gnt",  32'(gnt),  32'd0);
    chk("rstblk_busy", 32'(busy), 32'd0);
    chk("rstblk_beat", 32'(beat), 32'd0);
    chk("rstblk_done", 32'(done), 32'd0);
    step();
    chk("rstblk_nodn", 32'(done), 32'd0);
    chk("rstblk_noab", 32'(abort), 32'd0);
    $display("txn rstblk: reset mid-transfer");
    RST = 1'b0;
    exp_q.push_back(4'b1000);
    expect_grant("post_rst");
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    chk("post_rst_beat1", 32'(beat), 32'd1);
    req = 4'b0000; req_blk = 4'b0000;
    finish_txn("post_rst");
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
